// File: rtl/ppg_sample_collector_pkg.sv
// Shared definitions for the PPG sample collector: LED phase encoding,
// collector FSM states and the default timing that matches the oximeter
// controller's 10-cycle LED phase.
package ppg_sample_collector_pkg;

    typedef enum logic [1:0] {
        PH_NONE = 2'd0,
        PH_RED  = 2'd1,
        PH_IR   = 2'd2
    } phase_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        ACCUM  = 2'd2,
        HOLD   = 2'd3
    } state_t;

    localparam int DEF_SETTLE       = 2;
    localparam int DEF_AVG_LOG2     = 3;
    localparam int DEF_FIFO_DEPTH   = 4;
    localparam int LED_PHASE_CYCLES = 10;

    // Exactly one LED lit selects that phase; dark or both lit is no phase.
    function automatic phase_t decodePhase(input logic ledRed, input logic ledIr);
        phase_t ph;
        if (ledRed && !ledIr) begin
            ph = PH_RED;
        end else if (!ledRed && ledIr) begin
            ph = PH_IR;
        end else begin
            ph = PH_NONE;
        end
        return ph;
    endfunction

endpackage

// File: rtl/ppg_sample_collector_pair_fifo.sv
// Small synchronous FIFO holding {RED, IR} average pairs. Pointers carry one
// extra wrap bit so full and empty are distinguishable. A push while full is
// only accepted when a pop happens on the same edge.
module pair_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      r_wrPtr;
    logic [AW:0]      r_rdPtr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_doPush;
    logic             w_doPop;

    assign o_empty  = (r_wrPtr == r_rdPtr);
    assign o_full   = (r_wrPtr[AW] != r_rdPtr[AW]) &&
                      (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
    assign w_doPop  = i_pop && !o_empty;
    assign w_doPush = i_push && (!o_full || w_doPop);
    assign o_data   = r_mem[r_rdPtr[AW-1:0]];

    // Advance the read and write pointers on accepted pops and pushes.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
        end else begin
            if (w_doPush) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
        end
    end

    // Storage is not reset; the empty flag guards any stale contents.
    always_ff @(posedge i_clk) begin
        if (w_doPush) begin
            r_mem[r_wrPtr[AW-1:0]] <= i_data;
        end
    end

endmodule

// File: rtl/ppg_sample_collector.sv
// Consumer of the LED-multiplexed photodiode stream. Each LED phase drops its
// settling samples, box-averages the next 2^AVG_LOG2 samples, and a RED
// average followed by an IR average is pushed as one pair into a FIFO that
// downstream logic drains with a valid/ready handshake.
module ppg_sample_collector
    import ppg_sample_collector_pkg::*;
#(
    parameter int SETTLE     = DEF_SETTLE,
    parameter int AVG_LOG2   = DEF_AVG_LOG2,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic        CLK,
    input  logic        rst_n,
    input  logic        en,
    input  logic [7:0]  ADC,
    input  logic        LED_RED,
    input  logic        LED_IR,
    input  logic        ovf_clr,
    output logic        pair_valid,
    input  logic        pair_ready,
    output logic [7:0]  RED_avg,
    output logic [7:0]  IR_avg,
    output logic [15:0] pair_count,
    output logic        overflow
);

    localparam int         ACC_W       = 8 + AVG_LOG2;
    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE - 1);
    localparam logic [7:0] ACCUM_LAST  = 8'((1 << AVG_LOG2) - 1);
    localparam state_t     ST_SETTLE   = ppg_sample_collector_pkg::SETTLE;

    phase_t           w_phase;
    phase_t           r_prevPhase;
    logic             w_phaseChange;
    logic             w_phaseActive;
    state_t           r_state;
    state_t           w_stateNext;
    logic [7:0]       r_cnt;
    logic [7:0]       w_cntNext;
    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] w_accNext;
    logic [ACC_W-1:0] w_sum;
    logic [7:0]       w_avg;
    logic [7:0]       r_redHold;
    logic [7:0]       w_redHoldNext;
    logic             r_redPending;
    logic             w_redPendingNext;
    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    logic [15:0]      w_head;
    logic [15:0]      r_pairCount;
    logic             r_overflow;

    assign w_phase       = decodePhase(LED_RED, LED_IR);
    assign w_phaseChange = (w_phase != r_prevPhase);
    assign w_phaseActive = (w_phase != PH_NONE);
    assign w_sum         = r_acc + ACC_W'(ADC);
    assign w_avg         = w_sum[ACC_W-1:AVG_LOG2];

    // Next-state logic: enable gating, phase-change restarts, then the
    // settle/accumulate/hold sequence and RED/IR result handling.
    always_comb begin
        w_stateNext      = r_state;
        w_cntNext        = r_cnt;
        w_accNext        = r_acc;
        w_redHoldNext    = r_redHold;
        w_redPendingNext = r_redPending;
        w_push           = 1'b0;
        if (!en) begin
            w_stateNext      = IDLE;
            w_cntNext        = '0;
            w_accNext        = '0;
            w_redPendingNext = 1'b0;
        end else if ((r_state != IDLE) && w_phaseChange) begin
            if (w_phaseActive) begin
                w_stateNext = ST_SETTLE;
                w_cntNext   = 8'd1;
            end else begin
                w_stateNext = IDLE;
                w_cntNext   = '0;
            end
            w_accNext = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_phaseActive) begin
                        w_stateNext = ST_SETTLE;
                        w_cntNext   = '0;
                    end
                end
                ST_SETTLE: begin
                    if (r_cnt >= SETTLE_LAST) begin
                        w_stateNext = ACCUM;
                        w_cntNext   = '0;
                        w_accNext   = '0;
                    end else begin
                        w_cntNext = r_cnt + 8'd1;
                    end
                end
                ACCUM: begin
                    if (r_cnt == ACCUM_LAST) begin
                        w_stateNext = HOLD;
                        w_cntNext   = '0;
                        if (w_phase == PH_RED) begin
                            w_redHoldNext    = w_avg;
                            w_redPendingNext = 1'b1;
                        end else if (r_redPending) begin
                            w_push           = 1'b1;
                            w_redPendingNext = 1'b0;
                        end
                    end else begin
                        w_accNext = w_sum;
                        w_cntNext = r_cnt + 8'd1;
                    end
                end
                HOLD: begin
                    w_stateNext = HOLD;
                end
                default: begin
                    w_stateNext = IDLE;
                end
            endcase
        end
    end

    // Register the collector FSM, its counters and the phase history.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_acc        <= '0;
            r_redHold    <= '0;
            r_redPending <= 1'b0;
            r_prevPhase  <= PH_NONE;
        end else begin
            r_state      <= w_stateNext;
            r_cnt        <= w_cntNext;
            r_acc        <= w_accNext;
            r_redHold    <= w_redHoldNext;
            r_redPending <= w_redPendingNext;
            r_prevPhase  <= w_phase;
        end
    end

    assign w_pop = pair_valid && pair_ready;

    // Count every completed pair and latch a drop when the FIFO could not take it.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_pairCount <= '0;
            r_overflow  <= 1'b0;
        end else begin
            if (w_push) begin
                r_pairCount <= r_pairCount + 16'd1;
            end
            if (w_push && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end else if (ovf_clr) begin
                r_overflow <= 1'b0;
            end
        end
    end

    pair_fifo #(
        .WIDTH (16),
        .DEPTH (FIFO_DEPTH)
    ) u_pairFifo (
        .i_clk   (CLK),
        .i_rst_n (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  ({r_redHold, w_avg}),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign pair_valid = !w_empty;
    assign RED_avg    = pair_valid ? w_head[15:8] : 8'd0;
    assign IR_avg     = pair_valid ? w_head[7:0]  : 8'd0;
    assign pair_count = r_pairCount;
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_ppg_sample_collector.sv
// Directed bench for the PPG sample collector: drives LED phases and ADC
// samples as a linear sequence and compares outputs against hand-computed
// values just after each rising edge.
module tb_ppg_sample_collector;

    logic        CLK;
    logic        rst_n;
    logic        en;
    logic [7:0]  ADC;
    logic        LED_RED;
    logic        LED_IR;
    logic        ovf_clr;
    logic        pair_valid;
    logic        pair_ready;
    logic [7:0]  RED_avg;
    logic [7:0]  IR_avg;
    logic [15:0] pair_count;
    logic        overflow;

    int nChecks = 0;
    int nErrors = 0;

    ppg_sample_collector dut (
        .CLK        (CLK),
        .rst_n      (rst_n),
        .en         (en),
        .ADC        (ADC),
        .LED_RED    (LED_RED),
        .LED_IR     (LED_IR),
        .ovf_clr    (ovf_clr),
        .pair_valid (pair_valid),
        .pair_ready (pair_ready),
        .RED_avg    (RED_avg),
        .IR_avg     (IR_avg),
        .pair_count (pair_count),
        .overflow   (overflow)
    );

    // Free-running 10 ns clock.
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // One sample per edge; outputs are settled 1 ns after the edge.
    task automatic applyStimulus(input logic red, input logic ir, input logic [7:0] adc);
        LED_RED = red;
        LED_IR  = ir;
        ADC     = adc;
        @(posedge CLK);
        #1;
    endtask

    task automatic runPhase(input logic red, input logic ir, input logic [7:0] adc, input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(red, ir, adc);
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nChecks++;
        assert (observed === expected) else begin
            nErrors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Directed sequence covering every planned scenario in order.
    initial begin
        logic [7:0] redVal;
        logic [7:0] irVal;
        rst_n      = 1'b0;
        en         = 1'b0;
        ADC        = 8'd0;
        LED_RED    = 1'b0;
        LED_IR     = 1'b0;
        ovf_clr    = 1'b0;
        pair_ready = 1'b1;

        repeat (2) @(posedge CLK);
        #1;
        checkOutput("reset_valid", 32'(pair_valid), 32'd0);
        checkOutput("reset_red", 32'(RED_avg), 32'd0);
        checkOutput("reset_ir", 32'(IR_avg), 32'd0);
        checkOutput("reset_count", 32'(pair_count), 32'd0);
        checkOutput("reset_ovf", 32'(overflow), 32'd0);
        rst_n = 1'b1;
        en    = 1'b1;

        $display("[TB] constant signal");
        runPhase(1'b1, 1'b0, 8'd100, 10);
        runPhase(1'b0, 1'b1, 8'd150, 10);
        checkOutput("const_first_ir_unpaired", 32'(pair_valid), 32'd0);
        runPhase(1'b1, 1'b0, 8'd100, 10);
        runPhase(1'b0, 1'b1, 8'd150, 9);
        checkOutput("const_valid_before_s10", 32'(pair_valid), 32'd0);
        runPhase(1'b0, 1'b1, 8'd150, 1);
        checkOutput("const_valid_after_s10", 32'(pair_valid), 32'd1);
        checkOutput("const_red1", 32'(RED_avg), 32'd100);
        checkOutput("const_ir1", 32'(IR_avg), 32'd150);
        checkOutput("const_count1", 32'(pair_count), 32'd1);
        runPhase(1'b1, 1'b0, 8'd100, 10);
        checkOutput("const_popped", 32'(pair_valid), 32'd0);
        runPhase(1'b0, 1'b1, 8'd150, 10);
        checkOutput("const_valid2", 32'(pair_valid), 32'd1);
        checkOutput("const_count2", 32'(pair_count), 32'd2);

        $display("[TB] ramp and settle discard");
        for (int i = 0; i < 10; i++) begin
            redVal = (i < 2) ? 8'd0 : 8'(118 + i);
            applyStimulus(1'b1, 1'b0, redVal);
        end
        for (int i = 0; i < 10; i++) begin
            irVal = (i < 2) ? 8'd255 : 8'(58 + i);
            applyStimulus(1'b0, 1'b1, irVal);
        end
        checkOutput("ramp_valid", 32'(pair_valid), 32'd1);
        checkOutput("ramp_red", 32'(RED_avg), 32'd123);
        checkOutput("ramp_ir", 32'(IR_avg), 32'd63);
        checkOutput("ramp_count", 32'(pair_count), 32'd3);

        $display("[TB] backpressure and overflow");
        for (int k = 0; k < 5; k++) begin
            redVal = 8'(10 + 10 * k);
            irVal  = 8'(200 + k);
            if (k == 0) begin
                applyStimulus(1'b1, 1'b0, redVal);
                pair_ready = 1'b0;
                runPhase(1'b1, 1'b0, redVal, 9);
            end else begin
                runPhase(1'b1, 1'b0, redVal, 10);
            end
            runPhase(1'b0, 1'b1, irVal, 10);
            if (k == 3) begin
                checkOutput("bp_full_no_ovf", 32'(overflow), 32'd0);
            end
        end
        checkOutput("bp_valid", 32'(pair_valid), 32'd1);
        checkOutput("bp_ovf", 32'(overflow), 32'd1);
        checkOutput("bp_count", 32'(pair_count), 32'd8);
        pair_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            checkOutput("drain_red", 32'(RED_avg), 32'(10 + 10 * j));
            checkOutput("drain_ir", 32'(IR_avg), 32'(200 + j));
            applyStimulus(1'b0, 1'b0, 8'd0);
        end
        checkOutput("drain_empty", 32'(pair_valid), 32'd0);
        checkOutput("drain_ovf_sticky", 32'(overflow), 32'd1);
        ovf_clr = 1'b1;
        applyStimulus(1'b0, 1'b0, 8'd0);
        ovf_clr = 1'b0;
        checkOutput("ovf_cleared", 32'(overflow), 32'd0);

        $display("[TB] short phase");
        runPhase(1'b0, 1'b1, 8'd90, 10);
        runPhase(1'b1, 1'b0, 8'd80, 10);
        runPhase(1'b0, 1'b1, 8'd90, 6);
        checkOutput("short_no_pair", 32'(pair_valid), 32'd0);
        checkOutput("short_count", 32'(pair_count), 32'd8);
        runPhase(1'b1, 1'b0, 8'd60, 10);
        runPhase(1'b0, 1'b1, 8'd70, 10);
        checkOutput("short_next_valid", 32'(pair_valid), 32'd1);
        checkOutput("short_next_red", 32'(RED_avg), 32'd60);
        checkOutput("short_next_ir", 32'(IR_avg), 32'd70);
        checkOutput("short_next_count", 32'(pair_count), 32'd9);

        $display("[TB] illegal LED state and enable gating");
        runPhase(1'b1, 1'b0, 8'd33, 10);
        runPhase(1'b0, 1'b1, 8'd44, 6);
        runPhase(1'b1, 1'b1, 8'd44, 2);
        runPhase(1'b0, 1'b1, 8'd44, 4);
        checkOutput("illegal_no_pair", 32'(pair_valid), 32'd0);
        checkOutput("illegal_count", 32'(pair_count), 32'd9);
        runPhase(1'b1, 1'b0, 8'd55, 10);
        en = 1'b0;
        applyStimulus(1'b1, 1'b0, 8'd55);
        en = 1'b1;
        runPhase(1'b0, 1'b1, 8'd66, 11);
        checkOutput("en_gate_no_pair", 32'(pair_valid), 32'd0);
        checkOutput("en_gate_count", 32'(pair_count), 32'd9);
        runPhase(1'b1, 1'b0, 8'd77, 10);
        runPhase(1'b0, 1'b1, 8'd88, 10);
        checkOutput("recover_red", 32'(RED_avg), 32'd77);
        checkOutput("recover_ir", 32'(IR_avg), 32'd88);
        checkOutput("recover_count", 32'(pair_count), 32'd10);

        $display("[TB] async reset mid-accumulation");
        pair_ready = 1'b0;
        runPhase(1'b1, 1'b0, 8'd12, 5);
        checkOutput("prereset_valid", 32'(pair_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("areset_valid", 32'(pair_valid), 32'd0);
        checkOutput("areset_red", 32'(RED_avg), 32'd0);
        checkOutput("areset_ir", 32'(IR_avg), 32'd0);
        checkOutput("areset_count", 32'(pair_count), 32'd0);
        checkOutput("areset_ovf", 32'(overflow), 32'd0);
        @(posedge CLK);
        #1;
        rst_n = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
